// File: rtl/serial_tx_arb.sv
// Round-robin arbiter that shares one byte-level serial_tx among NUM_REQ message sources.
// Optional checksum byte (XOR of message bytes) enabled by defining SERIAL_TX_ARB_CHKSUM_EN.
module serial_tx_arb #(
    parameter int NUM_REQ  = 2,
    parameter int REQ_BITS = 1,
    parameter int MSG_LEN  = 4,
    parameter int MSG_BITS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_block,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*MSG_LEN*8-1:0] i_msg,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic                         o_done,
    output logic [REQ_BITS-1:0]          o_gnt_idx,
    output logic                         o_busy,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_new_data,
    input  logic                         i_tx_busy
);

    // state   | meaning
    // S_IDLE  | waiting for a request; grants and latches a message
    // S_SEND  | strobe next byte once serial_tx is free and not blocked
    // S_HOLD  | one cycle while serial_tx raises its busy flag
    // S_DRAIN | all bytes issued; wait for the last one to leave serial_tx
    // S_DONE  | completion pulse, then back to idle
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_HOLD, S_DRAIN, S_DONE} state_t;

    localparam int MSG_W = MSG_LEN * 8;

    state_t                r_state, w_next;
    logic [MSG_W-1:0]      r_shift;
    logic [MSG_BITS-1:0]   r_byte_cnt;
    logic                  r_msg_sent;
    logic [REQ_BITS-1:0]   r_last;
    logic [REQ_BITS-1:0]   r_gnt_idx;
    logic [NUM_REQ-1:0]    r_ack;
    logic [7:0]            r_tx_data;
    logic                  r_tx_new_data;

    logic                  w_found;
    logic [REQ_BITS-1:0]   w_pick;
    logic [REQ_BITS-1:0]   w_idx;
    logic                  w_grant;
    logic                  w_send;
    logic                  w_last_byte;
    logic [7:0]            w_byte;
    logic                  w_all_sent;

`ifdef SERIAL_TX_ARB_CHKSUM_EN
    logic [7:0]            r_chk;
    logic                  r_chk_sent;
    assign w_byte     = r_msg_sent ? r_chk : r_shift[7:0];
    assign w_all_sent = r_chk_sent;
`else
    assign w_byte     = r_shift[7:0];
    assign w_all_sent = r_msg_sent;
`endif

    // Scan starts just after the last grant so the previous winner ranks last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = REQ_BITS'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_grant     = (r_state == S_IDLE) && w_found && !i_block;
    assign w_send      = (r_state == S_SEND) && !i_tx_busy && !i_block;
    assign w_last_byte = (r_byte_cnt == MSG_BITS'(MSG_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_SEND;
            S_SEND:  if (w_send) w_next = S_HOLD;
            S_HOLD:  w_next = w_all_sent ? S_DRAIN : S_SEND;
            S_DRAIN: if (!i_tx_busy) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_msg_sent    <= 1'b0;
            r_last        <= REQ_BITS'(NUM_REQ - 1);
            r_gnt_idx     <= '0;
            r_ack         <= '0;
            r_tx_data     <= '0;
            r_tx_new_data <= 1'b0;
`ifdef SERIAL_TX_ARB_CHKSUM_EN
            r_chk         <= '0;
            r_chk_sent    <= 1'b0;
`endif
        end else begin
            r_ack         <= '0;
            r_tx_new_data <= 1'b0;
            if (w_grant) begin
                r_shift    <= i_msg[int'(w_pick)*MSG_W +: MSG_W];
                r_ack      <= NUM_REQ'(1) << w_pick;
                r_gnt_idx  <= w_pick;
                r_last     <= w_pick;
                r_byte_cnt <= '0;
                r_msg_sent <= 1'b0;
`ifdef SERIAL_TX_ARB_CHKSUM_EN
                r_chk      <= '0;
                r_chk_sent <= 1'b0;
`endif
            end
            if (w_send) begin
                r_tx_data     <= w_byte;
                r_tx_new_data <= 1'b1;
                if (!r_msg_sent) begin
                    r_shift <= r_shift >> 8;
`ifdef SERIAL_TX_ARB_CHKSUM_EN
                    r_chk   <= r_chk ^ r_shift[7:0];
`endif
                    // Counter parks on the last index instead of wrapping.
                    if (w_last_byte) r_msg_sent <= 1'b1;
                    else             r_byte_cnt <= r_byte_cnt + MSG_BITS'(1);
                end
`ifdef SERIAL_TX_ARB_CHKSUM_EN
                else begin
                    r_chk_sent <= 1'b1;
                end
`endif
            end
        end
    end

    assign o_ack         = r_ack;
    assign o_done        = (r_state == S_DONE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_gnt_idx     = r_gnt_idx;
    assign o_tx_data     = r_tx_data;
    assign o_tx_new_data = r_tx_new_data;

endmodule

// File: tb/tb_serial_tx_arb.sv
// Bench for serial_tx_arb: directed message table, multi-cycle corner sequences and a
// randomized run against a round-robin / byte-queue reference model with a serial_tx model.
module tb_serial_tx_arb;
    localparam int N  = 2;
    localparam int RB = 1;
    localparam int ML = 4;
    localparam int MB = 2;
`ifdef SERIAL_TX_ARB_CHKSUM_EN
    localparam int NB = ML + 1;
`else
    localparam int NB = ML;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            blk = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*ML*8-1:0] msg = '0;
    logic [N-1:0]    ack;
    logic            done;
    logic [RB-1:0]   gnt;
    logic            busy;
    logic [7:0]      txd;
    logic            txnd;
    logic            txb;
    logic            force_busy = 1'b0;
    logic            model_busy = 1'b0;

    assign txb = force_busy | model_busy;

    always #5 clk = ~clk;

    serial_tx_arb #(.NUM_REQ(N), .REQ_BITS(RB), .MSG_LEN(ML), .MSG_BITS(MB)) dut (
        .i_clk(clk), .i_rst(rst), .i_block(blk), .i_req(req), .i_msg(msg),
        .o_ack(ack), .o_done(done), .o_gnt_idx(gnt), .o_busy(busy),
        .o_tx_data(txd), .o_tx_new_data(txnd), .i_tx_busy(txb)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         ack_log[$];
    int         model_last = N - 1;
    bit         prev_busy = 1'b0;
    bit         prev_done = 1'b0;
    int         done_cnt = 0;
    bit         pend = 1'b0;
    int         tx_cnt = 0;
    int         tx_max = 3;
    bit         auto_drop = 1'b1;

    typedef struct {
        int          src;
        logic [31:0] m;
        logic [39:0] ex;   // expected bytes, LSB first; [39:32] is the XOR checksum
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] ea;
        logic [7:0]   xs;
        int           g;
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_ack", ack, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_new_data", txnd, 0);
            chk("rst_tx_data", txd, 0);
            chk("rst_gnt", gnt, 0);
            exp_q.delete();
            model_last = N - 1;
        end else begin
            ea = '0;
            g  = -1;
            if (!prev_busy && !blk) g = rr_pick(model_last, req);
            if (g >= 0) ea[g] = 1'b1;
            chk("ack", ack, ea);
            if (g >= 0) begin
                chk("gnt_idx", gnt, g);
                model_last = g;
                ack_log.push_back(g);
                xs = 8'h00;
                for (int b = 0; b < ML; b++) begin
                    exp_q.push_back(msg[g*ML*8 + b*8 +: 8]);
                    xs ^= msg[g*ML*8 + b*8 +: 8];
                end
`ifdef SERIAL_TX_ARB_CHKSUM_EN
                exp_q.push_back(xs);
`endif
            end
            if (txnd) begin
                chk("strobe_legal", {prev_busy, txb, blk}, 3'b100);
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("tx_byte", txd, exp_q.pop_front());
                got.push_back(txd);
            end
            if (done) begin
                chk("done_all_bytes", exp_q.size(), 0);
                chk("done_txb_ack", {txb, ack != 0}, 0);
                done_cnt++;
            end
            if (prev_busy && !busy) chk("busy_fall_after_done", prev_done, 1);
        end
        prev_busy = busy;
        prev_done = done;
        if (tx_cnt > 0) tx_cnt--;
        if (pend) begin
            tx_cnt = $urandom_range(tx_max, 1);
            pend = 1'b0;
        end
        if (txnd) pend = 1'b1;
        model_busy = (tx_cnt > 0);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        blk = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int cnt, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt - d0 < cnt && n < budget) begin
            step();
            n++;
        end
        chk(nm, done_cnt - d0, cnt);
    endtask

    task automatic wait_got(input string nm, input int cnt, input int budget);
        int n;
        n = 0;
        while (got.size() < cnt && n < budget) begin
            step();
            n++;
        end
        chk(nm, got.size(), cnt);
    endtask

    task automatic cmp_bytes(input string nm, input logic [39:0] ex);
        chk({nm, "_count"}, got.size(), NB);
        for (int b = 0; b < NB; b++) begin
            if (b < got.size()) chk(nm, got[b], ex[b*8 +: 8]);
        end
    endtask

    initial begin
        int a0;
        int d0;
        tbl[0] = '{0, 32'h81F0CCAA, 40'h17_81F0CCAA};
        tbl[1] = '{1, 32'h12345678, 40'h08_12345678};
        tbl[2] = '{0, 32'h00000000, 40'h00_00000000};
        tbl[3] = '{1, 32'hFFFFFFFF, 40'h00_FFFFFFFF};
        tbl[4] = '{1, 32'h01020408, 40'h0F_01020408};

        do_reset();

        // single-source messages from the table
        for (int t = 0; t < 5; t++) begin
            got.delete();
            req[tbl[t].src] = 1'b1;
            msg[tbl[t].src*32 +: 32] = tbl[t].m;
            wait_done("tbl_done", 1, 200);
            chk("tbl_gnt", gnt, tbl[t].src);
            cmp_bytes("tbl_byte", tbl[t].ex);
        end

        // both sources held from reset release: grants alternate 0,1,0,1
        do_reset();
        auto_drop = 1'b0;
        msg = {32'h44332211, 32'h81F0CCAA};
        req = 2'b11;
        a0 = ack_log.size();
        wait_done("rr_done", 4, 400);
        req = '0;
        auto_drop = 1'b1;
        chk("rr_ack_count", ack_log.size() - a0, 4);
        for (int k = 0; k < 4; k++) begin
            if (a0 + k < ack_log.size()) chk("rr_order", ack_log[a0 + k], k % 2);
        end

        // block holds off the grant, then pauses a message after byte 2
        got.delete();
        blk = 1'b1;
        req[1] = 1'b1;
        msg[32 +: 32] = 32'h44332211;
        a0 = ack_log.size();
        repeat (20) step();
        chk("blk_no_ack", ack_log.size() - a0, 0);
        chk("blk_no_strobe", got.size(), 0);
        blk = 1'b0;
        wait_got("blk_two_bytes", 2, 100);
        blk = 1'b1;
        repeat (30) step();
        chk("blk_paused", got.size(), 2);
        blk = 1'b0;
        wait_done("blk_done", 1, 200);
        cmp_bytes("blk_byte", 40'h44_44332211);

        // serial_tx busy for 100 cycles while a byte waits in SEND
        got.delete();
        force_busy = 1'b1;
        req[0] = 1'b1;
        msg[31:0] = 32'h81F0CCAA;
        a0 = ack_log.size();
        for (int n = 0; n < 20 && ack_log.size() == a0; n++) step();
        chk("hold_ack", ack_log.size() - a0, 1);
        repeat (100) step();
        chk("hold_no_strobe", got.size(), 0);
        force_busy = 1'b0;
        wait_got("hold_one_strobe", 1, 10);
        wait_done("hold_done", 1, 200);
        cmp_bytes("hold_byte", 40'h17_81F0CCAA);

        // reset right after the second strobe aborts without a done pulse
        got.delete();
        req[0] = 1'b1;
        msg[31:0] = 32'h81F0CCAA;
        wait_got("abort_two_bytes", 2, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        d0 = done_cnt;
        repeat (10) step();
        chk("abort_no_done", done_cnt - d0, 0);
        got.delete();
        req[0] = 1'b1;
        wait_done("abort_restart_done", 1, 200);
        cmp_bytes("abort_byte", 40'h17_81F0CCAA);

        // randomized traffic against the reference model
        tx_max = 5;
        a0 = ack_log.size();
        d0 = done_cnt;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    msg[i*32 +: 32] = $urandom();
                end else if (req[i] && $urandom_range(60, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            blk = ($urandom_range(7, 0) == 0);
            step();
        end
        req = '0;
        blk = 1'b0;
        for (int n = 0; n < 300 && busy; n++) step();
        chk("rand_idle", busy, 0);
        chk("rand_ack_vs_done", ack_log.size() - a0, done_cnt - d0);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
